// File: rtl/i2c_wb_sequencer.sv
// Sequences single-register I2C writes and reads through an OpenCores-style
// I2C master core by issuing WISHBONE accesses to its register file.
module i2c_wb_sequencer #(
  parameter logic [15:0] PRESCALE   = 16'h0063,
  parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       req_i,
  input  logic       rw_i,
  input  logic [6:0] dev_addr_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wr_data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_o,
  output logic       timeout_o,
  output logic [7:0] rd_data_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  output logic       wbm_we_o,
  output logic       wbm_stb_o,
  output logic       wbm_cyc_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i,
  output logic [3:0] state_o
);

  // Bus handshake: an access holds cyc=stb=1 with adr/dat/we stable until the
  // edge where ack=1 is sampled, then cyc/stb stay low for one full cycle.
  typedef enum logic [3:0] {
    INIT_PL, INIT_PH, INIT_CTR, IDLE, SEQ, POLL, STOP, DONE
  } state_t;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_POLL, OP_DONE} op_t;

  state_t      state;
  logic [3:0]  step;
  logic [15:0] poll_cnt;
  logic        stopping;
  logic        rw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wd_q;
  logic        cyc_q, stb_q;

  op_t         op;
  logic [2:0]  op_adr;
  logic [7:0]  op_dat;
  logic        acc_req;
  logic [2:0]  acc_adr;
  logic [7:0]  acc_dat;
  logic        acc_we;
  logic        acked;
  logic        poll_chk;

  // Step decode of the transaction script; steps 0-8 are shared by both
  // directions, a read continues with the NACK+STOP byte and the RXR fetch.
  always_comb begin
    op     = OP_DONE;
    op_adr = 3'd3;
    op_dat = 8'h00;
    case (step)
      4'd0: begin op = OP_WR; op_dat = {dev_q, 1'b0}; end
      4'd1: begin op = OP_WR; op_adr = 3'd4; op_dat = 8'h90; end
      4'd2, 4'd5, 4'd8: op = OP_POLL;
      4'd3: begin op = OP_WR; op_dat = reg_q; end
      4'd4: begin op = OP_WR; op_adr = 3'd4; op_dat = 8'h10; end
      4'd6: begin op = OP_WR; op_dat = rw_q ? {dev_q, 1'b1} : wd_q; end
      4'd7: begin op = OP_WR; op_adr = 3'd4; op_dat = rw_q ? 8'h90 : 8'h50; end
      4'd9: if (rw_q) begin op = OP_WR; op_adr = 3'd4; op_dat = 8'h68; end
      4'd10: if (rw_q) op = OP_POLL;
      4'd11: if (rw_q) op = OP_RD;
      default: op = OP_DONE;
    endcase
  end

  always_comb begin
    acc_req = 1'b1;
    acc_adr = 3'd0;
    acc_dat = 8'h00;
    acc_we  = 1'b1;
    case (state)
      INIT_PL:  acc_dat = PRESCALE[7:0];
      INIT_PH:  begin acc_adr = 3'd1; acc_dat = PRESCALE[15:8]; end
      INIT_CTR: begin acc_adr = 3'd2; acc_dat = 8'h80; end
      SEQ: begin
        acc_req = (op == OP_WR) || (op == OP_RD);
        acc_adr = op_adr;
        acc_dat = (op == OP_WR) ? op_dat : 8'h00;
        acc_we  = (op == OP_WR);
      end
      POLL:     begin acc_adr = 3'd4; acc_we = 1'b0; end
      STOP:     begin acc_adr = 3'd4; acc_dat = 8'h40; end
      default:  begin acc_req = 1'b0; acc_we = 1'b0; end
    endcase
  end

  assign acked    = acc_req && stb_q && wbm_ack_i;
  // RxACK after the final NACK+STOP read byte is expected to be 1.
  assign poll_chk = !(rw_q && step == 4'd10);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= INIT_PL;
      step      <= 4'd0;
      poll_cnt  <= 16'd0;
      stopping  <= 1'b0;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      reg_q     <= 8'd0;
      wd_q      <= 8'd0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      wbm_adr_o <= 3'd0;
      wbm_dat_o <= 8'd0;
      wbm_we_o  <= 1'b0;
      done_o    <= 1'b0;
      nack_o    <= 1'b0;
      timeout_o <= 1'b0;
      rd_data_o <= 8'd0;
    end else begin
      done_o <= 1'b0;
      if (acc_req && !stb_q) begin
        cyc_q     <= 1'b1;
        stb_q     <= 1'b1;
        wbm_adr_o <= acc_adr;
        wbm_dat_o <= acc_dat;
        wbm_we_o  <= acc_we;
      end else if (acked) begin
        cyc_q <= 1'b0;
        stb_q <= 1'b0;
      end

      case (state)
        INIT_PL:  if (acked) state <= INIT_PH;
        INIT_PH:  if (acked) state <= INIT_CTR;
        INIT_CTR: if (acked) state <= IDLE;
        IDLE: if (req_i) begin
          rw_q      <= rw_i;
          dev_q     <= dev_addr_i;
          reg_q     <= reg_addr_i;
          wd_q      <= wr_data_i;
          nack_o    <= 1'b0;
          timeout_o <= 1'b0;
          stopping  <= 1'b0;
          step      <= 4'd0;
          state     <= SEQ;
        end
        SEQ: begin
          if (op == OP_POLL) begin
            poll_cnt <= 16'd0;
            state    <= POLL;
          end else if (op == OP_DONE) begin
            state <= DONE;
          end else if (acked) begin
            if (op == OP_RD) begin
              rd_data_o <= wbm_dat_i;
              state     <= DONE;
            end else begin
              step <= step + 4'd1;
            end
          end
        end
        POLL: if (acked) begin
          poll_cnt <= poll_cnt + 16'd1;
          if (!wbm_dat_i[1]) begin
            if (stopping) begin
              state <= DONE;
            end else if (poll_chk && wbm_dat_i[7]) begin
              nack_o <= 1'b1;
              state  <= STOP;
            end else begin
              step  <= step + 4'd1;
              state <= SEQ;
            end
          end else if (poll_cnt + 16'd1 >= POLL_LIMIT) begin
            timeout_o <= 1'b1;
            state     <= DONE;
          end
        end
        STOP: if (acked) begin
          stopping <= 1'b1;
          poll_cnt <= 16'd0;
          state    <= POLL;
        end
        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= INIT_PL;
      endcase
    end
  end

  // Reset removes the bus request combinationally so a slave never sees a
  // strobe from a discarded transaction.
  assign wbm_cyc_o = cyc_q && !wb_rst_i;
  assign wbm_stb_o = stb_q && !wb_rst_i;
  assign busy_o    = (state != IDLE);
  assign state_o   = state;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Directed bench: a behavioural I2C-core register model answers the WISHBONE
// master, and every register write is logged and compared to the expected script.
module tb_i2c_wb_sequencer;

  logic       clk = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       req_i = 1'b0;
  logic       rw_i = 1'b0;
  logic [6:0] dev_addr_i = 7'd0;
  logic [7:0] reg_addr_i = 8'd0;
  logic [7:0] wr_data_i = 8'd0;
  logic       busy_o, done_o, nack_o, timeout_o;
  logic [7:0] rd_data_o;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic       wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_ack_i;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  i2c_wb_sequencer #(.PRESCALE(16'h0063), .POLL_LIMIT(16'd8)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .req_i(req_i), .rw_i(rw_i),
    .dev_addr_i(dev_addr_i), .reg_addr_i(reg_addr_i), .wr_data_i(wr_data_i),
    .busy_o(busy_o), .done_o(done_o), .nack_o(nack_o), .timeout_o(timeout_o),
    .rd_data_o(rd_data_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .state_o(state_o)
  );

  // ---------------- I2C core register model ----------------
  logic [7:0]  cfg_rxr = 8'h00;
  int          cfg_nack_at = 99;
  logic        cfg_stuck = 1'b0;
  logic        ack = 1'b0;
  logic [7:0]  rdat = 8'h00;
  logic        rxack = 1'b0;
  int          tip_left = 0;
  int          byte_cnt = 0;
  int          sr_reads = 0;
  int          done_cnt = 0;
  int          proto_err = 0;
  logic [10:0] wr_log[$];

  assign wbm_ack_i = ack;
  assign wbm_dat_i = rdat;

  always @(posedge clk) begin
    if (wb_rst_i) begin
      ack <= 1'b0; tip_left <= 0; rxack <= 1'b0; byte_cnt <= 0;
      sr_reads <= 0; done_cnt <= 0; wr_log.delete();
    end else begin
      ack <= 1'b0;
      if (done_o) done_cnt <= done_cnt + 1;
      if (req_i && !busy_o) begin
        byte_cnt <= 0; sr_reads <= 0; done_cnt <= 0; rxack <= 1'b0; wr_log.delete();
      end
      if (wbm_stb_o != wbm_cyc_o) proto_err <= proto_err + 1;
      if (wbm_cyc_o && wbm_stb_o && !ack) begin
        ack <= 1'b1;
        if (wbm_adr_o > 3'd4) proto_err <= proto_err + 1;
        if (wbm_we_o) begin
          wr_log.push_back({wbm_adr_o, wbm_dat_o});
          if (wbm_adr_o == 3'd2 && wbm_dat_o != 8'h80) proto_err <= proto_err + 1;
          if (wbm_adr_o == 3'd4) begin
            if (!(wbm_dat_o inside {8'h90, 8'h10, 8'h50, 8'h68, 8'h40}))
              proto_err <= proto_err + 1;
            if (wbm_dat_o[4] || wbm_dat_o[5]) begin
              rxack    <= (byte_cnt == cfg_nack_at);
              byte_cnt <= byte_cnt + 1;
            end
            tip_left <= 2;
          end
        end else if (wbm_adr_o == 3'd3) begin
          rdat <= cfg_rxr;
        end else if (wbm_adr_o == 3'd4) begin
          rdat     <= {rxack, 5'b0, (cfg_stuck || tip_left != 0), 1'b0};
          sr_reads <= sr_reads + 1;
          if (tip_left != 0) tip_left <= tip_left - 1;
        end else begin
          rdat <= 8'h00;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          tests = 0;
  int          fails = 0;
  logic [10:0] exp_q[$];

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic [7:0] rxr;
    int         nack_at;
    logic       stuck;
    logic       e_nack;
    logic       e_to;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_log(input string name);
    int bad_at;
    bad_at = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (bad_at < 0 && (i >= wr_log.size() || wr_log[i] !== exp_q[i])) bad_at = i;
    if (bad_at < 0 && wr_log.size() != exp_q.size()) bad_at = exp_q.size();
    tests++;
    if (bad_at >= 0) begin
      fails++;
      $display("FAIL %s: write log size %0d expected %0d, first diff at %0d got 0x%0h expected 0x%0h",
               name, wr_log.size(), exp_q.size(), bad_at,
               (bad_at < wr_log.size()) ? wr_log[bad_at] : 11'h7ff,
               (bad_at < exp_q.size()) ? exp_q[bad_at] : 11'h7ff);
    end
  endtask

  // Expected register writes: each byte is a TXR load (except the final read
  // byte) followed by its CR command; a NACKed byte adds STOP, a stuck TIP ends.
  task automatic build_exp(input vec_t v);
    logic [7:0] txr[4];
    logic [7:0] cr[4];
    int n;
    exp_q.delete();
    txr[0] = {v.dev, 1'b0}; cr[0] = 8'h90;
    txr[1] = v.rg;          cr[1] = 8'h10;
    txr[2] = v.rw ? {v.dev, 1'b1} : v.wd;
    cr[2]  = v.rw ? 8'h90 : 8'h50;
    txr[3] = 8'h00;         cr[3] = 8'h68;
    n = v.rw ? 4 : 3;
    for (int k = 0; k < n; k++) begin
      if (!(v.rw && k == 3)) exp_q.push_back({3'd3, txr[k]});
      exp_q.push_back({3'd4, cr[k]});
      if (v.stuck) break;
      if (k == v.nack_at && !(v.rw && k == 3)) begin
        exp_q.push_back({3'd4, 8'h40});
        break;
      end
    end
  endtask

  task automatic build_init_exp();
    exp_q.delete();
    exp_q.push_back({3'd0, 8'h63});
    exp_q.push_back({3'd1, 8'h00});
    exp_q.push_back({3'd2, 8'h80});
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_o) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy_o) begin ok = 1'b1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic drive_req(input vec_t v);
    cfg_rxr = v.rxr; cfg_nack_at = v.nack_at; cfg_stuck = v.stuck;
    rw_i = v.rw; dev_addr_i = v.dev; reg_addr_i = v.rg; wr_data_i = v.wd;
    req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    bit ok;
    v = vecs[idx];
    drive_req(v);
    wait_done(ok);
    check($sformatf("v%0d_done_seen", idx), ok, 1);
    if (ok) begin
      check($sformatf("v%0d_nack", idx), nack_o, v.e_nack);
      check($sformatf("v%0d_timeout", idx), timeout_o, v.e_to);
      check($sformatf("v%0d_rd_data", idx), rd_data_o, v.e_rd);
    end
    repeat (2) @(negedge clk);
    check($sformatf("v%0d_idle_after", idx), busy_o, 0);
    check($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
    if (v.stuck) check($sformatf("v%0d_sr_reads", idx), sr_reads, 8);
    build_exp(v);
    check_log($sformatf("v%0d_writes", idx));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"}, wbm_cyc_o, 0);
    check({tag, "_stb"}, wbm_stb_o, 0);
    check({tag, "_busy"}, busy_o, 1);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_nack"}, nack_o, 0);
    check({tag, "_timeout"}, timeout_o, 0);
    check({tag, "_rd_data"}, rd_data_o, 0);
    check({tag, "_state"}, state_o, 0);
  endtask

  initial begin
    vec_t h;
    bit ok;
    //            rw    dev     reg    wdata  rxr    nack stuck e_nack e_to e_rd
    vecs[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 99, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 7'h50, 8'h02, 8'h00, 8'h3C, 99, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[2] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00,  0, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[3] = '{1'b1, 7'h7F, 8'hFF, 8'h00, 8'hC3,  1, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[4] = '{1'b0, 7'h12, 8'h34, 8'h56, 8'h00,  2, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[5] = '{1'b1, 7'h21, 8'h80, 8'h00, 8'h00,  2, 1'b0, 1'b1, 1'b0, 8'h3C};
    vecs[6] = '{1'b1, 7'h21, 8'h80, 8'h00, 8'h81,  3, 1'b0, 1'b0, 1'b0, 8'h81};
    vecs[7] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 99, 1'b1, 1'b0, 1'b1, 8'h81};
    vecs[8] = '{1'b1, 7'h3B, 8'h07, 8'h00, 8'h5A, 99, 1'b0, 1'b0, 1'b0, 8'h5A};

    // Power-on reset and init writes.
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_adr", wbm_adr_o, 0);
    check("rst_dat", wbm_dat_o, 0);
    wb_rst_i = 1'b0;
    wait_idle("init_reaches_idle");
    build_init_exp();
    check_log("init_writes");

    for (int i = 0; i < 9; i++) run_vec(i);

    // req_i held high across done_o restarts on the following cycle.
    h = '{1'b0, 7'h11, 8'h22, 8'h33, 8'h00, 99, 1'b0, 1'b0, 1'b0, 8'h5A};
    cfg_rxr = h.rxr; cfg_nack_at = h.nack_at; cfg_stuck = h.stuck;
    rw_i = h.rw; dev_addr_i = h.dev; reg_addr_i = h.rg; wr_data_i = h.wd;
    req_i = 1'b1;
    wait_done(ok);
    check("held_first_done", ok, 1);
    @(negedge clk);
    check("held_restart_busy", busy_o, 1);
    req_i = 1'b0;
    wait_done(ok);
    check("held_second_done", ok, 1);
    repeat (2) @(negedge clk);
    check("held_idle_after", busy_o, 0);
    build_exp(h);
    check_log("held_second_writes");

    // Requests and input changes while busy are ignored.
    drive_req(vecs[0]);
    repeat (5) @(negedge clk);
    req_i = 1'b1; rw_i = 1'b1; dev_addr_i = 7'h7F; reg_addr_i = 8'h00; wr_data_i = 8'h00;
    repeat (3) @(negedge clk);
    req_i = 1'b0;
    wait_done(ok);
    check("busy_req_done", ok, 1);
    build_exp(vecs[0]);
    check_log("busy_req_writes");
    repeat (30) @(negedge clk);
    check("busy_req_no_extra_busy", busy_o, 0);
    check("busy_req_no_extra_done", done_cnt, 1);

    // Reset during the second poll discards the transaction and reruns init.
    drive_req(vecs[0]);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (wr_log.size() >= 4 && state_o == 4'd5 && wbm_stb_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("mid_reset_reached_poll2", ok, 1);
    wb_rst_i = 1'b1;
    #1;
    check("mid_reset_cyc_same_cycle", wbm_cyc_o, 0);
    check("mid_reset_stb_same_cycle", wbm_stb_o, 0);
    repeat (3) @(negedge clk);
    check_reset_outputs("mid_rst");
    wb_rst_i = 1'b0;
    wait_idle("mid_reset_reinit_idle");
    build_init_exp();
    check_log("mid_reset_init_writes");
    check("mid_reset_no_done", done_cnt, 0);
    check("mid_reset_cyc_idle", wbm_cyc_o, 0);

    check("protocol_errors", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_wb_sequencer.md
I2C_WB_SEQUENCER -- requirements
Module: i2c_wb_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 16'h0063, the I2C prescale value written to PRER at init (100 kHz SCL at 50 MHz).
REQ-002 SHALL have parameter POLL_LIMIT, default 16'hFFFF, the maximum number of SR reads per poll before timeout.
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_i, input, 1, transaction request, sampled only in IDLE.
REQ-006 SHALL have port rw_i, input, 1, direction: 0 is a register write, 1 is a register read.
REQ-007 SHALL have port dev_addr_i, input, 7, the 7-bit I2C slave address.
REQ-008 SHALL have port reg_addr_i, input, 8, the slave register index.
REQ-009 SHALL have port wr_data_i, input, 8, the byte written when rw_i=0.
REQ-010 SHALL have port busy_o, output, 1, high whenever not in IDLE.
REQ-011 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have ports nack_o, timeout_o, rd_data_o, outputs, 1/1/8, status and read byte, valid from done_o until the next accepted request.
REQ-013 SHALL have WISHBONE master ports wbm_adr_o (3), wbm_dat_o (8), wbm_we_o (1), wbm_stb_o (1), wbm_cyc_o (1) as outputs, and wbm_dat_i (8) and wbm_ack_i (1) as inputs, connected to the I2C core slave port.

Function
REQ-014 Register map used SHALL be: 0 PRERlo, 1 PRERhi, 2 CTR, 3 TXR(wr)/RXR(rd), 4 CR(wr)/SR(rd); adr 5-7 SHALL never be driven while stb is high.
REQ-015 Each bus access SHALL drive cyc=stb=1 with adr/dat/we stable until the cycle ack=1 is sampled, then drop cyc/stb for at least one cycle; only one access SHALL be outstanding.
REQ-016 CR writes SHALL only use these values: 0x90 (STA+WR), 0x10 (WR), 0x50 (STO+WR), 0x68 (RD+NACK+STO), 0x40 (STO); reserved bits SHALL be 0 and STA/STO and RD/WR SHALL never be set together.
REQ-017 CTR writes SHALL only use 0x80 (core enable, IRQ off); wbm_dat_o[5:0] SHALL be 0.
REQ-018 INIT states SHALL write PRERlo=PRESCALE[7:0], PRERhi=PRESCALE[15:8], CTR=0x80, in that order, then enter IDLE.
REQ-019 In IDLE with req_i=1, the block SHALL latch rw/dev/reg/data, clear nack/timeout, and start the next cycle.
REQ-020 Write sequence SHALL be: TXR={dev,0}; CR=0x90; POLL; TXR=reg; CR=0x10; POLL; TXR=data; CR=0x50; POLL; DONE.
REQ-021 Read sequence SHALL be: TXR={dev,0}; CR=0x90; POLL; TXR=reg; CR=0x10; POLL; TXR={dev,1}; CR=0x90; POLL; CR=0x68; POLL; read adr3 into rd_data_o; DONE.
REQ-022 POLL SHALL read SR repeatedly until SR[1] (TIP)=0, then check SR[7] (RxACK), except after the 0x68 command, where RxACK SHALL be ignored.
REQ-023 If RxACK=1 after an address or data write, the block SHALL set nack_o, write CR=0x40, poll TIP low (ignoring RxACK), and go to DONE.
REQ-024 The poll counter SHALL be 16-bit, cleared at each POLL entry and incremented per SR read; reaching POLL_LIMIT SHALL set timeout_o and go to DONE with no STO issued.
REQ-025 DONE SHALL pulse done_o for one cycle and then return to IDLE; req_i held high SHALL start a new transaction on the following cycle.
REQ-026 req_i outside IDLE SHALL be ignored, and inputs changing during a transaction SHALL have no effect.
REQ-027 rd_data_o SHALL be updated only by a successful read, and SHALL keep its value on nack or timeout.

Reset
REQ-028 While wb_rst_i=1, the block SHALL hold state=INIT_PL, cyc/stb/we=0, adr=0, dat_o=0, busy_o=1, done_o=0, nack_o=0, timeout_o=0, rd_data_o=0x00, and poll counter 0.
REQ-029 Reset asserted mid-transaction SHALL drop cyc/stb in the same cycle, discard the transaction, and rerun init after release.

Verification
REQ-030 Reset release with PRESCALE=0x0063 -> writes (0,0x63), (1,0x00), (2,0x80) in order, then busy_o=0.
REQ-031 Write dev=0x50, reg=0x10, data=0xA5, slave ACKs all -> TXR 0xA0, CR 0x90, TXR 0x10, CR 0x10, TXR 0xA5, CR 0x50; done_o one pulse; nack_o=0.
REQ-032 Read dev=0x50, reg=0x02, RXR model returns 0x3C -> third TXR write is 0xA1, CR 0x68 is issued, rd_data_o=0x3C at done_o.
REQ-033 RxACK=1 after the first byte -> no TXR=reg write, CR 0x40 issued, nack_o=1, done_o pulses.
REQ-034 TIP stuck at 1 with POLL_LIMIT=8 -> exactly 8 SR reads, then timeout_o=1 and done_o.
REQ-035 req_i pulsed while busy, and reset during the second POLL -> no extra transaction; after reset, cyc=0 and the init writes repeat.
